// File: rtl/operand_latch_p2_pkg.sv
// Shared widths, instruction field positions and FSM encoding for the p2 operand stage.
package operand_latch_p2_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int INSTR_W  = 16;
  localparam int RS_A_MSB = 13;
  localparam int RS_A_LSB = 11;
  localparam int RS_B_MSB = 10;
  localparam int RS_B_LSB = 8;
  localparam int CNT_W    = 4;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/operand_latch_p2_hazard_detect.sv
// Load-use hazard compare: a valid load in p3 writing a register that p2 reads.
module hazard_detect_p2 #(
  parameter int ADDR_W = 3
) (
  input  logic              valid_p2,
  input  logic              valid_p3,
  input  logic              mem_read_p3,
  input  logic [ADDR_W-1:0] write_addr_p3,
  input  logic [ADDR_W-1:0] read_addr_A,
  input  logic [ADDR_W-1:0] read_addr_B,
  output logic              hazard
);

  // Both source fields are compared even if the opcode only uses one.
  assign hazard = valid_p2 && valid_p3 && mem_read_p3 &&
                  ((write_addr_p3 == read_addr_A) || (write_addr_p3 == read_addr_B));

endmodule

// File: rtl/operand_latch_p2.sv
// p2 decode/operand stage: operand select, load-use stall and p3 pipeline register.
// Optional OPERAND_LATCH_STATS_EN adds saturating fwd_count/stall_count outputs.
module operand_latch_p2 #(
  parameter int DATA_W            = operand_latch_p2_pkg::DATA_W,
  parameter int ADDR_W            = operand_latch_p2_pkg::ADDR_W,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       instr_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] rf_data_A,
  input  logic [DATA_W-1:0] rf_data_B,
  input  logic [DATA_W-1:0] fowarding_data_A,
  input  logic [DATA_W-1:0] fowarding_data_B,
  input  logic              to_foward_or_not_A,
  input  logic              to_foward_or_not_B,
  input  logic              mem_read_p3,
  input  logic [ADDR_W-1:0] write_addr_p3,
  input  logic              flush,
  output logic [ADDR_W-1:0] read_addr_A,
  output logic [ADDR_W-1:0] read_addr_B,
  output logic              stall_p1,
  output logic [15:0]       instr_p3,
  output logic [DATA_W-1:0] operand_A_p3,
  output logic [DATA_W-1:0] operand_B_p3,
  output logic              valid_p3
`ifdef OPERAND_LATCH_STATS_EN
  ,
  output logic [15:0]       fwd_count,
  output logic [15:0]       stall_count
`endif
);

  import operand_latch_p2_pkg::*;

  logic [15:0]       instr_p2;
  logic              valid_p2;
  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              hazard;
  logic              advance;
  logic [DATA_W-1:0] op_a, op_b;

  assign read_addr_A = instr_p2[RS_A_MSB:RS_A_LSB];
  assign read_addr_B = instr_p2[RS_B_MSB:RS_B_LSB];

  assign op_a = to_foward_or_not_A ? fowarding_data_A : rf_data_A;
  assign op_b = to_foward_or_not_B ? fowarding_data_B : rf_data_B;

  hazard_detect_p2 #(.ADDR_W(ADDR_W)) u_hazard (
    .valid_p2      (valid_p2),
    .valid_p3      (valid_p3),
    .mem_read_p3   (mem_read_p3),
    .write_addr_p3 (write_addr_p3),
    .read_addr_A   (read_addr_A),
    .read_addr_B   (read_addr_B),
    .hazard        (hazard)
  );

  // Flush outranks any hazard or pending stall; the first hazard cycle is itself a bubble.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_p1   = 1'b0;
    advance    = 1'b0;
    if (reset) begin
      state_next = RUN;
      cnt_next   = '0;
    end else if (flush) begin
      state_next = RUN;
      cnt_next   = '0;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            stall_p1 = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_next = STALL;
              cnt_next   = CNT_W'(LOAD_STALL_CYCLES - 2);
            end
          end else begin
            advance = 1'b1;
          end
        end
        STALL: begin
          stall_p1 = 1'b1;
          if (cnt == '0) state_next = RUN;
          else           cnt_next   = cnt - CNT_W'(1);
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      cnt          <= '0;
      instr_p2     <= '0;
      valid_p2     <= 1'b0;
      instr_p3     <= '0;
      operand_A_p3 <= '0;
      operand_B_p3 <= '0;
      valid_p3     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (advance || flush) begin
        instr_p2     <= instr_in;
        instr_p3     <= instr_p2;
        operand_A_p3 <= op_a;
        operand_B_p3 <= op_b;
      end
      valid_p2 <= flush ? 1'b0 : (advance ? valid_in : valid_p2);
      valid_p3 <= advance ? valid_p2 : 1'b0;
    end
  end

`ifdef OPERAND_LATCH_STATS_EN
  logic [1:0]  fwd_inc;
  logic [16:0] fwd_sum;

  assign fwd_inc = (advance && valid_p2) ?
                   ({1'b0, to_foward_or_not_A} + {1'b0, to_foward_or_not_B}) : 2'd0;
  assign fwd_sum = {1'b0, fwd_count} + {15'd0, fwd_inc};

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else begin
      fwd_count <= fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
      if (stall_p1 && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_latch_p2.sv
// Directed bench for operand_latch_p2: vector table on a 1-bubble instance, hand sequences on a 3-bubble one.
module tb_operand_latch_p2;

  logic        clock;
  logic        reset;
  logic [15:0] instr_in;
  logic        valid_in;
  logic [15:0] rf_data_A, rf_data_B, fowarding_data_A, fowarding_data_B;
  logic        to_foward_or_not_A, to_foward_or_not_B;
  logic        mem_read_p3;
  logic [2:0]  write_addr_p3;
  logic        flush;

  logic [2:0]  ra_a1, ra_b1, ra_a3, ra_b3;
  logic        stall1, stall3, valid1, valid3;
  logic [15:0] instr1, instr3, opa1, opa3, opb1, opb3;
`ifdef OPERAND_LATCH_STATS_EN
  logic [15:0] fwd_cnt1, stall_cnt1, fwd_cnt3, stall_cnt3;
`endif

  int total;
  int bad;

  operand_latch_p2 #(.LOAD_STALL_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .instr_in(instr_in), .valid_in(valid_in),
    .rf_data_A(rf_data_A), .rf_data_B(rf_data_B),
    .fowarding_data_A(fowarding_data_A), .fowarding_data_B(fowarding_data_B),
    .to_foward_or_not_A(to_foward_or_not_A), .to_foward_or_not_B(to_foward_or_not_B),
    .mem_read_p3(mem_read_p3), .write_addr_p3(write_addr_p3), .flush(flush),
    .read_addr_A(ra_a1), .read_addr_B(ra_b1), .stall_p1(stall1),
    .instr_p3(instr1), .operand_A_p3(opa1), .operand_B_p3(opb1), .valid_p3(valid1)
`ifdef OPERAND_LATCH_STATS_EN
    , .fwd_count(fwd_cnt1), .stall_count(stall_cnt1)
`endif
  );

  operand_latch_p2 #(.LOAD_STALL_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .instr_in(instr_in), .valid_in(valid_in),
    .rf_data_A(rf_data_A), .rf_data_B(rf_data_B),
    .fowarding_data_A(fowarding_data_A), .fowarding_data_B(fowarding_data_B),
    .to_foward_or_not_A(to_foward_or_not_A), .to_foward_or_not_B(to_foward_or_not_B),
    .mem_read_p3(mem_read_p3), .write_addr_p3(write_addr_p3), .flush(flush),
    .read_addr_A(ra_a3), .read_addr_B(ra_b3), .stall_p1(stall3),
    .instr_p3(instr3), .operand_A_p3(opa3), .operand_B_p3(opb3), .valid_p3(valid3)
`ifdef OPERAND_LATCH_STATS_EN
    , .fwd_count(fwd_cnt3), .stall_count(stall_cnt3)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] instr;
    logic        valid;
    logic [15:0] rfa, rfb, fwa, fwb;
    logic        sela, selb, mem_rd;
    logic [2:0]  waddr;
    logic        flush;
    logic        exp_stall;
    logic        chk_data;
    logic [15:0] exp_instr, exp_a, exp_b;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [7:0] lo);
    return {2'b00, a, b, lo};
  endfunction

  task automatic check_output(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    instr_in           = v.instr;
    valid_in           = v.valid;
    rf_data_A          = v.rfa;
    rf_data_B          = v.rfb;
    fowarding_data_A   = v.fwa;
    fowarding_data_B   = v.fwb;
    to_foward_or_not_A = v.sela;
    to_foward_or_not_B = v.selb;
    mem_read_p3        = v.mem_rd;
    write_addr_p3      = v.waddr;
    flush              = v.flush;
  endtask

  // One cycle of the dut3 hand sequence: stall sampled mid-cycle, p3 sampled after the edge.
  task automatic step3(input string name, input logic [15:0] instr, input logic mem_rd,
                       input logic [2:0] waddr, input logic fl, input logic exp_stall,
                       input logic exp_valid);
    vec_t v;
    v = '{instr, 1'b1, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1'b0, 1'b0, mem_rd,
          waddr, fl, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0};
    apply_stimulus(v);
    @(negedge clock);
    check_output({name, ".stall"}, {15'd0, stall3}, {15'd0, exp_stall});
    @(posedge clock);
    #1;
    check_output({name, ".valid_p3"}, {15'd0, valid3}, {15'd0, exp_valid});
  endtask

  logic [15:0] i0, i1, i2, i3, i4, i5, i6, i7, i8;
  logic [15:0] j0, j1, j2, j3;

  initial begin
    total = 0;
    bad   = 0;
    i0 = mk(3'd1, 3'd2, 8'h01);
    i1 = mk(3'd3, 3'd4, 8'h02);
    i2 = mk(3'd5, 3'd3, 8'h03);
    i3 = mk(3'd6, 3'd0, 8'h04);
    i4 = mk(3'd2, 3'd2, 8'h05);
    i5 = mk(3'd1, 3'd1, 8'h06);
    i6 = mk(3'd4, 3'd5, 8'h07);
    i7 = mk(3'd7, 3'd7, 8'h08);
    i8 = mk(3'd0, 3'd1, 8'h09);
    j0 = mk(3'd1, 3'd3, 8'h10);
    j1 = mk(3'd2, 3'd5, 8'h11);
    j2 = mk(3'd6, 3'd4, 8'h12);
    j3 = mk(3'd0, 3'd0, 8'h13);

    //            instr valid rfa      rfb      fwa      fwb      sA   sB   mem  wa    fl   stall chk  exp_instr exp_a    exp_b    exp_v
    vecs[0] = '{i0, 1'b1, 16'h0101, 16'h0202, 16'h0F0F, 16'h0E0E, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0101, 16'h0202, 1'b0};
    vecs[1] = '{i1, 1'b1, 16'h1111, 16'h2222, 16'hAAAA, 16'hCCCC, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, i0,        16'hAAAA, 16'h2222, 1'b1};
    vecs[2] = '{i2, 1'b1, 16'h3333, 16'hDDDD, 16'hEEEE, 16'hBBBB, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, i1,        16'h3333, 16'hBBBB, 1'b1};
    vecs[3] = '{i3, 1'b1, 16'h4444, 16'h5555, 16'h9999, 16'h8888, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, i1,        16'h3333, 16'hBBBB, 1'b0};
    vecs[4] = '{i3, 1'b1, 16'h6666, 16'h7777, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, i2,        16'h6666, 16'h7777, 1'b1};
    vecs[5] = '{i4, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{i5, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[7] = '{i6, 1'b0, 16'h1357, 16'h2468, 16'hF00D, 16'hBEEF, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, i5,        16'hF00D, 16'h2468, 1'b1};
    vecs[8] = '{i7, 1'b1, 16'h0A0A, 16'h0B0B, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, i6,        16'h0A0A, 16'h0B0B, 1'b0};
    vecs[9] = '{i8, 1'b1, 16'h0C0C, 16'h0D0D, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, i7,        16'h0C0C, 16'h0D0D, 1'b1};

    // Reset held two cycles with live-looking inputs.
    reset = 1'b1;
    apply_stimulus('{16'hFFFF, 1'b1, 16'h5A5A, 16'hA5A5, 16'h1111, 16'h2222, 1'b1, 1'b1,
                     1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0});
    @(posedge clock);
    @(posedge clock);
    #1;
    check_output("rst.instr_p3", instr1, 16'h0000);
    check_output("rst.opA", opa1, 16'h0000);
    check_output("rst.opB", opb1, 16'h0000);
    check_output("rst.valid_p3", {15'd0, valid1}, 16'h0000);
    check_output("rst.stall", {15'd0, stall1}, 16'h0000);
    check_output("rst.read_addr_A", {13'd0, ra_a1}, 16'h0000);
    check_output("rst.valid_p3_3", {15'd0, valid3}, 16'h0000);
    check_output("rst.stall_3", {15'd0, stall3}, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clock);
      check_output($sformatf("v%0d.stall", i), {15'd0, stall1}, {15'd0, vecs[i].exp_stall});
      @(posedge clock);
      #1;
      check_output($sformatf("v%0d.valid_p3", i), {15'd0, valid1}, {15'd0, vecs[i].exp_valid});
      if (vecs[i].chk_data) begin
        check_output($sformatf("v%0d.instr_p3", i), instr1, vecs[i].exp_instr);
        check_output($sformatf("v%0d.opA", i), opa1, vecs[i].exp_a);
        check_output($sformatf("v%0d.opB", i), opb1, vecs[i].exp_b);
      end
    end

`ifdef OPERAND_LATCH_STATS_EN
    check_output("stats.fwd_count", fwd_cnt1, 16'd3);
    check_output("stats.stall_count", stall_cnt1, 16'd1);
`endif

    // Fresh start for the three-bubble instance.
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    step3("s3c0", j0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step3("s3c1", j1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    check_output("s3c1.instr_p3", instr3, j0);
    check_output("s3c1.read_addr_A", {13'd0, ra_a3}, 16'd2);
    check_output("s3c1.read_addr_B", {13'd0, ra_b3}, 16'd5);
    step3("s3c2", j2, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
    step3("s3c3", j2, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
    step3("s3c4", j2, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
    check_output("s3c4.instr_p3_hold", instr3, j0);
    step3("s3c5", j2, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
    check_output("s3c5.instr_p3", instr3, j1);
    // Second hazard, flushed in its second stall cycle.
    step3("s3c6", j3, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
    step3("s3c7", j3, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    step3("s3c8", j3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    step3("s3c9", j0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    check_output("s3c9.instr_p3", instr3, j3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
